// File: rtl/mic_capture_ctrl_if.sv
// Capture write bus between the PDM sample strobe and BRAM port B.
// master: the capture controller (consumes the strobe, drives address/wen).
// slave:  the sample source / BRAM side.
interface mic_capture_ctrl_if;
    logic        mic_data_valid;
    logic [31:0] address;
    logic [3:0]  wen;

    modport master (
        input  mic_data_valid,
        output address,
        output wen
    );

    modport slave (
        output mic_data_valid,
        input  address,
        input  wen
    );
endinterface

// File: rtl/mic_capture_ctrl.sv
// Write-side controller for the per-microphone capture BRAMs.
// Produces one shared byte address / write enable per sample strobe, manages the
// buffer as two ping-pong halves with sticky ready flags and a sticky overrun flag.
// Optional debug taps and a non-wrapping write counter are built when the macro
// CAPTURE_DBG_EN is defined.
module mic_capture_ctrl #(
    parameter int unsigned COUNT_WIDTH = 14,
    parameter bit          ONE_SHOT    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [1:0]             ack_half,
    mic_capture_ctrl_if.master     bus,
    output logic [1:0]             half_ready,
    output logic                   overrun,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] word_idx
`ifdef CAPTURE_DBG_EN
    ,
    output logic [31:0]            address_dbg,
    output logic [3:0]             wen_dbg,
    output logic [31:0]            sample_total
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_WORD  = '1;
    localparam logic [COUNT_WIDTH-1:0] HALF_WORD  = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] HALF_LAST  = {1'b0, {(COUNT_WIDTH-1){1'b1}}};

    state_t      state;
    logic        arm_d;
    logic        arm_rise;
    logic        do_write;
    logic [1:0]  set_half;
    logic        ovr_hit;
    logic [31:0] word_addr;

    // Decode this cycle's write and the flag events it produces.
    always_comb begin
        arm_rise    = arm & ~arm_d;
        // A strobe seen while arm is already low is dropped.
        do_write    = (state == StRun) & arm & bus.mic_data_valid;
        set_half[0] = do_write & (word_idx == HALF_LAST);
        set_half[1] = do_write & (word_idx == LAST_WORD);
        // Refilling a half the PS has not yet released.
        ovr_hit     = do_write & (((word_idx == '0) & half_ready[0]) |
                                  ((word_idx == HALF_WORD) & half_ready[1]));
        word_addr   = 32'({word_idx, 2'b00});
    end

    // Capture FSM with registered address/wen and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            arm_d       <= 1'b0;
            bus.address <= '0;
            bus.wen     <= '0;
            half_ready  <= '0;
            overrun     <= 1'b0;
            running     <= 1'b0;
            word_idx    <= '0;
        end else begin
            arm_d      <= arm;
            bus.wen    <= '0;
            // Set has priority over a same-cycle ack.
            half_ready <= (half_ready & ~ack_half) | set_half;
            case (state)
                StIdle: begin
                    if (arm_rise) begin
                        state      <= StRun;
                        running    <= 1'b1;
                        word_idx   <= '0;
                        half_ready <= '0;
                        overrun    <= 1'b0;
                    end
                end
                StRun: begin
                    if (!arm) begin
                        state   <= StIdle;
                        running <= 1'b0;
                    end else if (do_write) begin
                        bus.address <= word_addr;
                        bus.wen     <= 4'hF;
                        word_idx    <= word_idx + 1'b1;
                        if (ovr_hit) begin
                            overrun <= 1'b1;
                        end
                        if (ONE_SHOT && (word_idx == LAST_WORD)) begin
                            state   <= StDone;
                            running <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (!arm) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state   <= StIdle;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_DBG_EN
    // Independent copies of address/wen for the ILA, plus a total write count.
    always_ff @(posedge clk) begin
        if (rst) begin
            address_dbg  <= '0;
            wen_dbg      <= '0;
            sample_total <= '0;
        end else begin
            wen_dbg <= do_write ? 4'hF : 4'h0;
            if (do_write) begin
                address_dbg  <= word_addr;
                sample_total <= sample_total + 32'd1;
            end else if ((state == StIdle) && arm_rise) begin
                sample_total <= '0;
            end
        end
    end
`endif

endmodule
